// File: rtl/reg_file_sb_pkg.sv
// Shared types and sizes for the register file and its write scoreboard.
// No logic, no latency, no flow control.
package reg_file_sb_pkg;
    typedef logic [4:0] reg_add_t;

    localparam int NUM_REGS = 32;
    localparam int SB_CNT_W = 2;
    localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = 2'd3;
endpackage

// File: rtl/reg_file_sb_if.sv
// Issue and retire events seen by the scoreboard; the pipeline drives them and the scoreboard consumes.
// Pure wiring: zero latency, no backpressure of its own (the stall comes back separately).
interface reg_file_sb_if;
    import reg_file_sb_pkg::*;

    logic     issue;
    logic     issue_regwrite;
    reg_add_t issue_rd_add;
    logic     wb_regwrite;
    reg_add_t wb_rd_add;

    modport master (output issue, issue_regwrite, issue_rd_add, wb_regwrite, wb_rd_add);
    modport slave  (input  issue, issue_regwrite, issue_rd_add, wb_regwrite, wb_rd_add);
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register count of issued-but-unretired writes; busy is combinational, counts update at the edge.
// Never backpressures; over/underflow holds the count and sets a sticky error.
module reg_scoreboard
    import reg_file_sb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    reg_file_sb_if.slave        req,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                err_o
);
    logic [SB_CNT_W-1:0] cnt_q [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_d [NUM_REGS];
    logic                err_q;
    logic                err_d;
    logic                inc;
    logic                dec;

    always_comb begin
        cnt_d  = cnt_q;
        err_d  = err_q;
        busy_o = '0;
        inc    = 1'b0;
        dec    = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc = req.issue & req.issue_regwrite & (req.issue_rd_add == reg_add_t'(r));
            dec = req.wb_regwrite & (req.wb_rd_add == reg_add_t'(r));
            // The last pending write retiring now is served by the WB bypass.
            busy_o[r] = (cnt_q[r] != '0) & !((cnt_q[r] == SB_CNT_W'(1)) & dec);
            if (inc && !dec) begin
                if (cnt_q[r] == SB_CNT_MAX) err_d = 1'b1;
                else                        cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with write-first WB bypass and RAW-hazard scoreboard; reads are 0-cycle.
// Backpressure is ID_stall_o: high while a used source has a write in flight not retiring this cycle.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  reg_add_t              ID_rs1_add_i,
    input  reg_add_t              ID_rs2_add_i,
    input  logic                  ID_rs1_used_i,
    input  logic                  ID_rs2_used_i,
    input  logic                  ID_issue_i,
    input  logic                  ID_issue_regwrite_i,
    input  reg_add_t              ID_issue_rd_add_i,
    input  logic                  WB_regwrite_i,
    input  reg_add_t              WB_rd_add_i,
    input  logic [DATA_WIDTH-1:0] WB_data_write_reg_i,
    output logic [DATA_WIDTH-1:0] ID_rs1_data_o,
    output logic [DATA_WIDTH-1:0] ID_rs2_data_o,
    output logic                  ID_stall_o,
    output logic                  SB_err_o
);
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;

    reg_file_sb_if sb_req ();

    assign sb_req.issue          = ID_issue_i;
    assign sb_req.issue_regwrite = ID_issue_regwrite_i;
    assign sb_req.issue_rd_add   = ID_issue_rd_add_i;
    assign sb_req.wb_regwrite    = WB_regwrite_i;
    assign sb_req.wb_rd_add      = WB_rd_add_i;

    reg_scoreboard u_sb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (sb_req.slave),
        .busy_o (busy),
        .err_o  (SB_err_o)
    );

    // Entry 0 is reset and never written, so it always reads as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (WB_regwrite_i && (WB_rd_add_i != '0)) begin
            regs_q[WB_rd_add_i] <= WB_data_write_reg_i;
        end
    end

    assign ID_rs1_data_o = (ID_rs1_add_i == '0) ? '0 :
                           (WB_regwrite_i && (WB_rd_add_i == ID_rs1_add_i)) ? WB_data_write_reg_i :
                           regs_q[ID_rs1_add_i];
    assign ID_rs2_data_o = (ID_rs2_add_i == '0) ? '0 :
                           (WB_regwrite_i && (WB_rd_add_i == ID_rs2_add_i)) ? WB_data_write_reg_i :
                           regs_q[ID_rs2_add_i];

    assign ID_stall_o = (ID_rs1_used_i & busy[ID_rs1_add_i]) |
                        (ID_rs2_used_i & busy[ID_rs2_add_i]);
endmodule
